mem_load_unit: RTL

Parametrised memory-access stage between EX and WB. It registers the EX result under stall/flush control and waits on a variable-latency data SRAM with a valid handshake. It extracts and sign- or zero-extends byte, half, word and (at XLEN=64) double loads, flags misaligned accesses, and drives both the WB interface and the ID bypass path. It replaces the fixed-width, word-only, fixed-latency MEM stage.

---
 rtl/mem_load_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - MEM stage: stage register, variable-latency load return, extension, misalign/timeout flags
//
// Holds the EX result under stall/flush control, waits on the data SRAM
// rvalid handshake, extracts and extends B/H/W/D loads and drives WB/bypass.
// Optional feature macro: MEM_LOAD_TIMEOUT_EN (bounded wait with load_timeout).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_stall[5:0]            stall vector; [3] = MEM stop, [4] = WB stop
//   i_flush                 kill the instruction entering or held in MEM
//   i_ex_*                  EX slot: valid, pc, rf_we, rf_waddr, result (load address), load_op
//   i_data_sram_rdata/rvalid  little-endian read data and its valid
//   o_stallreq_mem          stall request while waiting for load data
//   o_wb_*                  WB / bypass interface
//   o_load_misalign/timeout exception flags aligned to o_wb_valid
module mem_load_unit #(
   parameter int          XLEN     = 32,
   parameter int          RF_AW    = 5,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [5:0]       i_stall,
   input  logic             i_flush,
   input  logic             i_ex_valid,
   input  logic [31:0]      i_ex_pc,
   input  logic             i_ex_rf_we,
   input  logic [RF_AW-1:0] i_ex_rf_waddr,
   input  logic [XLEN-1:0]  i_ex_result,
   input  logic [2:0]       i_ex_load_op,
   input  logic [XLEN-1:0]  i_data_sram_rdata,
   input  logic             i_data_sram_rvalid,
   output logic             o_stallreq_mem,
   output logic             o_wb_valid,
   output logic [31:0]      o_wb_pc,
   output logic             o_wb_rf_we,
   output logic [RF_AW-1:0] o_wb_rf_waddr,
   output logic [XLEN-1:0]  o_wb_rf_wdata,
   output logic             o_load_misalign,
   output logic             o_load_timeout
);

   localparam int OFF_W = $clog2(XLEN / 8);

   localparam logic [2:0] OP_NONE = 3'b000;
   localparam logic [2:0] OP_LB   = 3'b001;
   localparam logic [2:0] OP_LBU  = 3'b010;
   localparam logic [2:0] OP_LH   = 3'b011;
   localparam logic [2:0] OP_LHU  = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_LWU  = 3'b110;
   localparam logic [2:0] OP_LD   = 3'b111;

   typedef enum logic {S_IDLE, S_HAVE} state_t;

   logic             r_valid;
   logic [31:0]      r_pc;
   logic             r_rf_we;
   logic [RF_AW-1:0] r_waddr;
   logic [XLEN-1:0]  r_result;
   logic [2:0]       r_load_op;
   logic [XLEN-1:0]  r_buf;
   state_t           r_state;
   state_t           w_state_nxt;

   logic             w_hold;
   logic             w_is_load;
   logic             w_misalign;
   logic             w_timeout;
   logic             w_capture;
   logic [OFF_W-1:0] w_off;
   logic [XLEN-1:0]  w_raw;
   logic [XLEN-1:0]  w_shifted;
   logic [XLEN-1:0]  w_ext;
   logic             w_unused;

   // Held means the stage register keeps its contents this edge.
   assign w_hold = ~i_rst & ~i_flush & i_stall[3] & i_stall[4];

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush || (i_stall[3] && !i_stall[4])) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_rf_we   <= 1'b0;
         r_waddr   <= '0;
         r_result  <= '0;
         r_load_op <= OP_NONE;
      end else if (!i_stall[3]) begin
         r_valid   <= i_ex_valid;
         r_pc      <= i_ex_pc;
         r_rf_we   <= i_ex_rf_we;
         r_waddr   <= i_ex_rf_waddr;
         r_result  <= i_ex_result;
         r_load_op <= i_ex_load_op;
      end
   end

   assign w_off     = r_result[OFF_W-1:0];
   assign w_is_load = r_valid & (r_load_op != OP_NONE);

   always_comb begin
      w_misalign = 1'b0;
      case (r_load_op)
         OP_LH, OP_LHU: w_misalign = w_off[0];
         OP_LW, OP_LWU: w_misalign = |w_off[1:0];
         OP_LD:         w_misalign = |w_off;
         default:       w_misalign = 1'b0;
      endcase
   end

`ifdef MEM_LOAD_TIMEOUT_EN
   localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   logic [CNT_W-1:0] r_wait_cnt;

   // Counts stalled cycles of the held instruction; any stage change restarts it.
   always_ff @(posedge i_clk) begin
      if (i_rst || !w_hold) begin
         r_wait_cnt <= '0;
      end else if (o_stallreq_mem) begin
         r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
   end

   assign w_timeout = w_is_load & (r_wait_cnt == CNT_W'(MAX_WAIT));
   assign w_unused  = ^{i_stall[5], i_stall[2:0]};
`else
   logic [31:0] w_unused_max;
   assign w_unused_max = MAX_WAIT;
   assign w_timeout    = 1'b0;
   assign w_unused     = ^{i_stall[5], i_stall[2:0], w_unused_max};
`endif

   // Data arriving while the stage is held would be lost; park it in r_buf.
   assign w_capture = (r_state == S_IDLE) & w_is_load & ~w_misalign & ~w_timeout
                      & i_data_sram_rvalid & w_hold;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_buf   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_capture) begin
            r_buf <= i_data_sram_rdata;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_capture) w_state_nxt = S_HAVE;
         S_HAVE:  if (!w_hold)   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_raw     = (r_state == S_HAVE) ? r_buf : i_data_sram_rdata;
   assign w_shifted = w_raw >> {w_off, 3'b000};

   always_comb begin
      w_ext = w_shifted;
      case (r_load_op)
         OP_LB:   w_ext = XLEN'(signed'(w_shifted[7:0]));
         OP_LBU:  w_ext = XLEN'(w_shifted[7:0]);
         OP_LH:   w_ext = XLEN'(signed'(w_shifted[15:0]));
         OP_LHU:  w_ext = XLEN'(w_shifted[15:0]);
         // A 32-bit datapath returns the whole bus word for word loads.
         OP_LW:   w_ext = (XLEN == 32) ? w_raw : XLEN'(signed'(w_shifted[31:0]));
         OP_LWU:  w_ext = (XLEN == 32) ? w_raw : XLEN'(w_shifted[31:0]);
         default: w_ext = w_shifted;
      endcase
   end

   assign o_stallreq_mem  = w_is_load & ~w_misalign & (r_state == S_IDLE)
                            & ~i_data_sram_rvalid & ~w_timeout;
   assign o_load_misalign = w_is_load & w_misalign;
   assign o_load_timeout  = w_timeout;
   assign o_wb_valid      = r_valid;
   assign o_wb_pc         = r_pc;
   assign o_wb_rf_waddr   = r_waddr;
   assign o_wb_rf_we      = r_valid & r_rf_we & ~o_load_misalign & ~o_load_timeout;
   assign o_wb_rf_wdata   = (r_load_op != OP_NONE) ? w_ext : r_result;

endmodule
